// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving a registered 4:1 mux
// Optional hold limiting: define MUX_ARB_HOLD_LIMIT_EN to force release after MAX_HOLD cycles.
module mux_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic             s1,
  output logic             s0,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] d,
  output logic             valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             found;
  logic             any_req;
  logic             hold_done;
  logic             release_c;
  logic             grant_now;
  logic [WIDTH-1:0] sel_data;

  // ptr is the last granted index, which is also the current grant while BUSY
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 1; k < 5; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = i0;
    case ({s1, s0})
      2'd0: sel_data = i0;
      2'd1: sel_data = i1;
      2'd2: sel_data = i2;
      2'd3: sel_data = i3;
      default: sel_data = i0;
    endcase
  end

  assign any_req   = |req;
  assign release_c = ~req[ptr] | hold_done;
  assign grant_now = any_req && ((state == IDLE) || release_c);

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt;

  assign hold_done = (state == BUSY) && (cnt == CW'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (grant_now) begin
      cnt <= CW'(1);
    end else if (state == BUSY && cnt != CW'(MAX_HOLD)) begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign hold_done = (MAX_HOLD < 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      s1    <= 1'b0;
      s0    <= 1'b0;
      ptr   <= 2'd3;
      d     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= (state == BUSY);
      if (state == BUSY) begin
        d <= sel_data;
      end
      if (grant_now) begin
        state    <= BUSY;
        gnt      <= 4'b0001 << pick;
        {s1, s0} <= pick;
        ptr      <= pick;
      end else if (state == BUSY && release_c) begin
        state <= IDLE;
        gnt   <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter
module tb_mux_rr_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [W-1:0] i0 = '0, i1 = '0, i2 = '0, i3 = '0;
  logic         s1, s0, valid;
  logic [3:0]   gnt;
  logic [W-1:0] d;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  bit           mon_en = 1'b0;
  bit           exp_busy = 1'b0;
  logic [1:0]   exp_idx = 2'd0;

  mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .s1(s1), .s0(s0), .gnt(gnt), .d(d), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] in_of(input logic [1:0] k);
    case (k)
      2'd0: return i0;
      2'd1: return i1;
      2'd2: return i2;
      default: return i3;
    endcase
  endfunction

  // expected d is captured from the inputs driven ahead of the edge that loads it
  task automatic cycle(input logic [3:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
    i0 = W'($urandom);
    i1 = W'($urandom);
    i2 = W'($urandom);
    i3 = W'($urandom);
    if (exp_busy && !rs) exp_q.push_back(in_of(exp_idx));
    @(posedge clk);
    #1;
  endtask

  always begin
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (mon_en) begin
      n_cmp++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (valid !== 1'b1 || d !== e) begin
          n_bad++;
          $display("FAIL data: valid=%b d=%h required valid=1 d=%h at %0t", valid, d, e, $time);
        end
      end else if (valid !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_valid: valid=%b required 0 at %0t", valid, $time);
      end
    end
  end

  task automatic test_reset;
    cycle(4'hf, 1'b1);
    cycle(4'hf, 1'b1);
    n_cmp++;
    if ({gnt, s1, s0, valid} !== 7'b0 || d !== '0) begin
      n_bad++;
      $display("FAIL reset_state: gnt=%b sel=%b%b valid=%b d=%h required all zero", gnt, s1, s0, valid, d);
    end
    mon_en = 1'b1;
    exp_busy = 1'b0;
    cycle(4'hf, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0001 || {s1, s0} !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_first_grant: gnt=%b sel=%b%b required 0001 sel=00", gnt, s1, s0);
    end
    exp_busy = 1'b1;
    exp_idx = 2'd0;
    cycle(4'h0, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_release: gnt=%b required 0000", gnt);
    end
    exp_busy = 1'b0;
    cycle(4'h0, 1'b0);
  endtask

  task automatic test_single;
    cycle(4'b0010, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0010 || {s1, s0} !== 2'd1) begin
      n_bad++;
      $display("FAIL single_grant: gnt=%b sel=%b%b required 0010 sel=01", gnt, s1, s0);
    end
    exp_busy = 1'b1;
    exp_idx = 2'd1;
    for (int k = 0; k < 2; k++) begin
      cycle(4'b0010, 1'b0);
      n_cmp++;
      if (gnt !== 4'b0010) begin
        n_bad++;
        $display("FAIL single_hold: gnt=%b required 0010", gnt);
      end
    end
    cycle(4'b0000, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0000 || valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_drop: gnt=%b valid=%b required gnt=0000 valid=1", gnt, valid);
    end
    exp_busy = 1'b0;
    cycle(4'b0000, 1'b0);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_valid_fall: valid=%b required 0", valid);
    end
  endtask

  task automatic test_hold;
    logic [1:0] e;
    logic [3:0] eg;
    cycle(4'h0, 1'b1);
    exp_busy = 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    for (int k = 0; k < 40; k++) begin
      cycle(4'hf, 1'b0);
      e = 2'((k / 8) % 4);
      eg = 4'b0001 << e;
      n_cmp++;
      if (gnt !== eg || {s1, s0} !== e) begin
        n_bad++;
        $display("FAIL fairness k=%0d: gnt=%b sel=%b%b required %b sel=%0d", k, gnt, s1, s0, eg, e);
      end
      exp_busy = 1'b1;
      exp_idx = e;
    end
    for (int k = 0; k < 10; k++) begin
      cycle(4'b0001, 1'b0);
      n_cmp++;
      if (gnt !== 4'b0001) begin
        n_bad++;
        $display("FAIL regrant_self k=%0d: gnt=%b required 0001", k, gnt);
      end
    end
`else
    for (int k = 0; k < 20; k++) begin
      cycle(4'hf, 1'b0);
      n_cmp++;
      if (gnt !== 4'b0001 || {s1, s0} !== 2'd0) begin
        n_bad++;
        $display("FAIL no_limit_hold k=%0d: gnt=%b required 0001", k, gnt);
      end
      exp_busy = 1'b1;
      exp_idx = 2'd0;
    end
    cycle(4'b1110, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0010 || {s1, s0} !== 2'd1) begin
      n_bad++;
      $display("FAIL no_limit_next: gnt=%b required 0010", gnt);
    end
    exp_idx = 2'd1;
`endif
    cycle(4'h0, 1'b0);
    exp_busy = 1'b0;
    cycle(4'h0, 1'b0);
  endtask

  task automatic test_simultaneous;
    cycle(4'h0, 1'b1);
    exp_busy = 1'b0;
    cycle(4'b0100, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0100 || {s1, s0} !== 2'd2) begin
      n_bad++;
      $display("FAIL simul_setup: gnt=%b required 0100", gnt);
    end
    exp_busy = 1'b1;
    exp_idx = 2'd2;
    cycle(4'b0100, 1'b0);
    cycle(4'b1001, 1'b0);
    n_cmp++;
    if (gnt !== 4'b1000 || {s1, s0} !== 2'd3) begin
      n_bad++;
      $display("FAIL simul_switch: gnt=%b sel=%b%b required 1000 sel=11", gnt, s1, s0);
    end
    exp_idx = 2'd3;
    cycle(4'h0, 1'b0);
    exp_busy = 1'b0;
    cycle(4'h0, 1'b0);
  endtask

  task automatic test_reset_mid;
    cycle(4'h0, 1'b1);
    exp_busy = 1'b0;
    cycle(4'b0100, 1'b0);
    exp_busy = 1'b1;
    exp_idx = 2'd2;
    cycle(4'b0100, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0100 || valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_setup: gnt=%b valid=%b required 0100 valid=1", gnt, valid);
    end
    cycle(4'hf, 1'b1);
    n_cmp++;
    if (gnt !== 4'b0000 || {s1, s0} !== 2'd0 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: gnt=%b sel=%b%b valid=%b required 0000 00 0", gnt, s1, s0, valid);
    end
    exp_busy = 1'b0;
    cycle(4'hf, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL mid_regrant: gnt=%b required 0001", gnt);
    end
    exp_busy = 1'b1;
    exp_idx = 2'd0;
    cycle(4'h0, 1'b0);
    exp_busy = 1'b0;
    cycle(4'h0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_single;
    test_hold;
    test_simultaneous;
    test_reset_mid;
    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
